// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a three-state fetch/exec/trap sequencer that owns the PC,
// latches fetched instruction words, resolves branch/JAL/JALR redirects and counts retirements.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 Imem_Req_o,
  output logic [31:0]          Imem_Addr_o,
  input  logic                 Imem_Ready_i,
  input  logic [31:0]          Imem_Data_i,
  input  logic                 Retire_i,
  input  logic                 Stall_i,
  input  logic                 Branch_Taken_i,
  input  logic                 Jal_i,
  input  logic                 JalR_i,
  input  logic [31:0]          Target_i,
  input  logic [31:0]          JalR_Target_i,
  output logic [31:0]          Instr_o,
  output logic [6:0]           Opcode_o,
  output logic                 Instr_Valid_o,
  output logic [31:0]          PC_o,
  output logic [31:0]          PC_Plus4_o,
  output logic                 Misalign_o,
  output logic [CNT_WIDTH-1:0] Retired_Cnt_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t               r_state;
  state_t               w_nextState;
  logic [31:0]          r_pc;
  logic [31:0]          r_instr;
  logic                 r_misalign;
  logic [CNT_WIDTH-1:0] r_retiredCnt;
  logic [31:0]          w_pcPlus4;
  logic [31:0]          w_jalrTarget;
  logic [31:0]          w_nextPc;
  logic                 w_retire;
  logic                 w_nextMisaligned;

  assign w_pcPlus4        = r_pc + 32'd4;
  // JALR clears bit 0 of its target, but bit 1 can still leave the PC misaligned.
  assign w_jalrTarget     = JalR_Target_i & 32'hFFFF_FFFE;
  assign w_retire         = (r_state == S_EXEC) && Retire_i && !Stall_i;
  assign w_nextMisaligned = |w_nextPc[1:0];

  always_comb begin
    w_nextPc = w_pcPlus4;
    if (JalR_i) begin
      w_nextPc = w_jalrTarget;
    end else if (Jal_i || Branch_Taken_i) begin
      w_nextPc = Target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    Imem_Req_o    = 1'b0;
    Instr_Valid_o = 1'b0;
    case (r_state)
      S_FETCH: begin
        Imem_Req_o = 1'b1;
        if (Imem_Ready_i) begin
          w_nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        Instr_Valid_o = 1'b1;
        if (w_retire) begin
          w_nextState = w_nextMisaligned ? S_TRAP : S_FETCH;
        end
      end
      S_TRAP: begin
        w_nextState = S_TRAP;
      end
      default: begin
        w_nextState = S_FETCH;
      end
    endcase
  end

  // A misaligned redirect still retires the instruction but leaves the PC on it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_misalign   <= 1'b0;
      r_retiredCnt <= '0;
    end else begin
      if ((r_state == S_FETCH) && Imem_Ready_i) begin
        r_instr <= Imem_Data_i;
      end
      if (w_retire) begin
        r_retiredCnt <= r_retiredCnt + CNT_WIDTH'(1);
        if (w_nextMisaligned) begin
          r_misalign <= 1'b1;
        end else begin
          r_pc <= w_nextPc;
        end
      end
    end
  end

  assign Imem_Addr_o   = r_pc;
  assign PC_o          = r_pc;
  assign PC_Plus4_o    = w_pcPlus4;
  assign Instr_o       = r_instr;
  assign Opcode_o      = r_instr[6:0];
  assign Misalign_o    = r_misalign;
  assign Retired_Cnt_o = r_retiredCnt;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, PC value loaded on reset.
REQ-002 Parameter CNT_WIDTH, default 16, width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
REQ-005 Imem_Req_o  output  1  instruction memory read request.
REQ-006 Imem_Addr_o  output  32  instruction memory byte address; equals PC_o.
REQ-007 Imem_Ready_i  input  1  Imem_Data_i valid this cycle; meaningful only while Imem_Req_o=1.
REQ-008 Imem_Data_i  input  32  fetched instruction word.
REQ-009 Retire_i  input  1  downstream has consumed the current instruction.
REQ-010 Stall_i  input  1  downstream hold; while 1, Retire_i is ignored.
REQ-011 Branch_Taken_i  input  1  conditional branch resolved taken (Branch qualified by compare result).
REQ-012 Jal_i  input  1  current instruction is JAL.
REQ-013 JalR_i  input  1  current instruction is JALR.
REQ-014 Target_i  input  32  PC-relative target for branch/JAL.
REQ-015 JalR_Target_i  input  32  rs1+imm target for JALR.
REQ-016 Instr_o  output  32  registered instruction word.
REQ-017 Opcode_o  output  7  Instr_o[6:0], drives the control unit opcode input.
REQ-018 Instr_Valid_o  output  1  Instr_o/Opcode_o hold a valid instruction.
REQ-019 PC_o  output  32  address of the current instruction.
REQ-020 PC_Plus4_o  output  32  PC_o+4, modulo 2^32 (link value for JAL/JALR).
REQ-021 Misalign_o  output  1  sticky fetch-misalignment error.
REQ-022 Retired_Cnt_o  output  CNT_WIDTH  count of retired instructions.

Function
REQ-023 FSM states: S_FETCH, S_EXEC, S_TRAP.
REQ-024 S_FETCH: Imem_Req_o=1, Instr_Valid_o=0; on Imem_Ready_i=1, Instr_o <= Imem_Data_i and next state = S_EXEC; else remain in S_FETCH with PC unchanged.
REQ-025 S_EXEC: Imem_Req_o=0, Instr_Valid_o=1; Instr_o and PC_o are held stable.
REQ-026 S_EXEC with Retire_i=1 and Stall_i=0: PC <= next PC, Retired_Cnt_o increments, next state = S_FETCH.
REQ-027 Next-PC priority: JalR_i -> {JalR_Target_i[31:1],1'b0}; else Jal_i -> Target_i; else Branch_Taken_i -> Target_i; else PC+4.
REQ-028 Redirect inputs are sampled only on the retire cycle; their values in any other cycle have no effect.
REQ-029 If the selected next PC has bits[1:0] != 0 on a retire cycle: PC is not updated, Misalign_o <= 1, the counter still increments, and next state = S_TRAP.
REQ-030 S_TRAP: Imem_Req_o=0 and Instr_Valid_o=0; the FSM remains in S_TRAP until reset.
REQ-031 Minimum throughput: 2 cycles per instruction (one fetch cycle with immediate ready, one exec cycle with immediate retire).
REQ-032 PC+4 and Retired_Cnt_o wrap modulo 2^32 and 2^CNT_WIDTH respectively, with no flag.
REQ-033 Opcode_o is a pure slice of Instr_o and carries no extra latency.

Reset
REQ-034 reset=0 at any clock edge: PC_o=RESET_PC, Instr_o=32'h0000_0013 (NOP), Instr_Valid_o=0, Misalign_o=0, Retired_Cnt_o=0, state=S_FETCH.
REQ-035 Reset asserted while waiting for Imem_Ready_i: the pending response is discarded, and fetch restarts from RESET_PC on the first cycle after reset=1.
REQ-036 Imem_Req_o is 1 in the first cycle after reset is released.

Verification
REQ-037 Sequential: ready always 1, Retire_i every exec cycle, 3 instructions -> PC_o sequence 0x00400000, 0x00400004, 0x00400008; Retired_Cnt_o=3; 6 cycles total.
REQ-038 Memory wait: Imem_Ready_i low 3 cycles -> Imem_Req_o held at 1 and Imem_Addr_o stable; Instr_Valid_o rises the cycle after ready.
REQ-039 Priority: JalR_i=Jal_i=1, JalR_Target_i=0x00400105, Target_i=0x00400200 -> next PC_o=0x00400104.
REQ-040 Stall: Retire_i=1 with Stall_i=1 for 2 cycles -> PC_o and Instr_o unchanged; retire on the first cycle after Stall_i drops.
REQ-041 Misalign: Branch_Taken_i=1 with Target_i=0x00400002 -> Misalign_o=1, S_TRAP entered, Imem_Req_o stays 0 until reset.
REQ-042 Mid-fetch reset: reset=0 for one cycle while in S_FETCH at PC 0x0040000C -> PC_o=0x00400000, Instr_o=0x00000013, Misalign_o=0, Retired_Cnt_o=0.
